// File: rtl/fp_pkg.sv
// Shared types and constants for the 24-bit float multiply scheduler:
// sign[23], exponent[22:16] (bias 63), fraction[15:0] with hidden 1.
package fp_pkg;

  localparam int FP_W     = 24;
  localparam int EXP_W    = 7;
  localparam int FRAC_W   = 16;
  localparam int EXP_BIAS = 63;

  localparam int SIGN_BIT = 23;
  localparam int EXP_MSB  = 22;
  localparam int EXP_LSB  = 16;
  localparam int FRAC_MSB = 15;
  localparam int FRAC_LSB = 0;

  typedef enum logic {ARB, LOCK} sched_state_e;

  function automatic logic [FP_W-1:0] fp_pack(input logic             s,
                                               input logic [EXP_W-1:0]  e,
                                               input logic [FRAC_W-1:0] f);
    return {s, e, f};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible request scanning from
// ptr+1 (mod N_REQ); requests flagged in excl are skipped.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  input  logic [N_REQ-1:0] excl,
  output logic [N_REQ-1:0] gnt
);

  logic [N_REQ-1:0] elig;
  logic [IW-1:0]    idx;
  logic             found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    elig  = req & ~excl;
    // k runs 1..N_REQ so the pointer's own slot is visited last
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % N_REQ);
      if (!found && elig[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpmul_sched.sv
// Round-robin scheduler sharing one pipelined float multiplier among N_REQ
// requesters; tags ride a shift pipe so results return to their owners.
module fpmul_sched
  import fp_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int LATENCY   = 3,
  parameter int BURST_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_lock,
  input  logic [FP_W*N_REQ-1:0]   req_op_a,
  input  logic [FP_W*N_REQ-1:0]   req_op_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    issue_valid,
  output logic [FP_W-1:0]         issue_a,
  output logic [FP_W-1:0]         issue_b,
  input  logic                    dp_sign,
  input  logic [EXP_W-1:0]        dp_exp,
  input  logic [FRAC_W-1:0]       dp_mant,
  input  logic                    dp_ovf,
  input  logic                    dp_unf,
  output logic [N_REQ-1:0]        res_valid,
  output logic [FP_W-1:0]         res_data,
  output logic                    res_ovf,
  output logic                    res_unf,
  output logic                    busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BMAX = BW'(BURST_MAX);

  sched_state_e state_q, state_d;
  logic [IW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]            burst_q, burst_d;
  logic [LATENCY:0]         vld_pipe_q, vld_pipe_d;
  logic [LATENCY:0][IW-1:0] idx_pipe_q, idx_pipe_d;
  logic [FP_W-1:0]          issue_a_q, issue_a_d, issue_b_q, issue_b_d;
  logic [N_REQ-1:0]         res_valid_q, res_valid_d;
  logic [FP_W-1:0]          res_data_q, res_data_d;
  logic                     res_ovf_q, res_ovf_d, res_unf_q, res_unf_d;

  logic [N_REQ-1:0] owner_mask, arb_excl, arb_gnt;
  logic             owner_hold, owner_grant, others_pending, at_limit, xfer;
  logic [IW-1:0]    gidx;
  logic [FP_W-1:0]  sel_a, sel_b;

  // In LOCK, rr_ptr_q doubles as the owner index.
  always_comb begin
    owner_mask           = '0;
    owner_mask[rr_ptr_q] = 1'b1;
    owner_hold     = (state_q == LOCK) && req_valid[rr_ptr_q] && req_lock[rr_ptr_q];
    others_pending = |(req_valid & ~owner_mask);
    at_limit       = (burst_q == BMAX);
    owner_grant    = owner_hold && !(at_limit && others_pending);
    arb_excl       = owner_hold ? owner_mask : '0;
    req_ready      = owner_grant ? owner_mask : arb_gnt;
  end

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req  (req_valid),
    .ptr  (rr_ptr_q),
    .excl (arb_excl),
    .gnt  (arb_gnt)
  );

  always_comb begin
    xfer  = |req_ready;
    gidx  = '0;
    sel_a = req_op_a[FP_W-1:0];
    sel_b = req_op_b[FP_W-1:0];
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        gidx  = IW'(i);
        sel_a = req_op_a[i*FP_W +: FP_W];
        sel_b = req_op_b[i*FP_W +: FP_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    if (owner_grant) begin
      if (!at_limit) burst_d = burst_q + BW'(1);
    end else if (xfer) begin
      rr_ptr_d = gidx;
      burst_d  = BW'(1);
      state_d  = req_lock[gidx] ? LOCK : ARB;
    end else begin
      state_d  = ARB;
    end
  end

  // Stage 0 is the issue register; stage LATENCY lines up with dp_*.
  always_comb begin
    vld_pipe_d    = '0;
    idx_pipe_d    = idx_pipe_q;
    vld_pipe_d[0] = xfer;
    idx_pipe_d[0] = xfer ? gidx : idx_pipe_q[0];
    for (int s = 1; s <= LATENCY; s++) begin
      vld_pipe_d[s] = vld_pipe_q[s-1];
      idx_pipe_d[s] = idx_pipe_q[s-1];
    end
    issue_a_d = xfer ? sel_a : issue_a_q;
    issue_b_d = xfer ? sel_b : issue_b_q;
  end

  always_comb begin
    res_valid_d = '0;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    res_unf_d   = res_unf_q;
    if (vld_pipe_q[LATENCY]) begin
      res_valid_d[idx_pipe_q[LATENCY]] = 1'b1;
      res_data_d = fp_pack(dp_sign, dp_exp, dp_mant);
      res_ovf_d  = dp_ovf;
      res_unf_d  = dp_unf;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      burst_q     <= '0;
      vld_pipe_q  <= '0;
      idx_pipe_q  <= '0;
      issue_a_q   <= '0;
      issue_b_q   <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_unf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_q     <= burst_d;
      vld_pipe_q  <= vld_pipe_d;
      idx_pipe_q  <= idx_pipe_d;
      issue_a_q   <= issue_a_d;
      issue_b_q   <= issue_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
      res_unf_q   <= res_unf_d;
    end
  end

  assign issue_valid = vld_pipe_q[0];
  assign issue_a     = issue_a_q;
  assign issue_b     = issue_b_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_ovf     = res_ovf_q;
  assign res_unf     = res_unf_q;
  assign busy        = (|vld_pipe_q) | (|res_valid_q);

endmodule

// File: tb/tb_fpmul_sched.sv
// Directed bench for fpmul_sched; a stand-in datapath returns operand B as
// the product and takes ovf/unf from operand A bits 0/1, LATENCY cycles on.
module tb_fpmul_sched;

  localparam int N   = 4;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid, req_lock, req_ready, res_valid;
  logic [24*N-1:0] req_op_a, req_op_b;
  logic          issue_valid, dp_sign, dp_ovf, dp_unf, res_ovf, res_unf, busy;
  logic [23:0]   issue_a, issue_b, res_data;
  logic [6:0]    dp_exp;
  logic [15:0]   dp_mant;

  int total = 0;
  int bad   = 0;

  fpmul_sched #(.N_REQ(N), .LATENCY(LAT), .BURST_MAX(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_lock(req_lock),
    .req_op_a(req_op_a), .req_op_b(req_op_b), .req_ready(req_ready),
    .issue_valid(issue_valid), .issue_a(issue_a), .issue_b(issue_b),
    .dp_sign(dp_sign), .dp_exp(dp_exp), .dp_mant(dp_mant),
    .dp_ovf(dp_ovf), .dp_unf(dp_unf), .res_valid(res_valid),
    .res_data(res_data), .res_ovf(res_ovf), .res_unf(res_unf), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [23:0] dqa [LAT];
  logic [23:0] dqb [LAT];
  always @(posedge clk) begin
    dqa[0] <= issue_a;
    dqb[0] <= issue_b;
    for (int s = 1; s < LAT; s++) begin
      dqa[s] <= dqa[s-1];
      dqb[s] <= dqb[s-1];
    end
  end
  assign dp_sign = dqb[LAT-1][23];
  assign dp_exp  = dqb[LAT-1][22:16];
  assign dp_mant = dqb[LAT-1][15:0];
  assign dp_ovf  = dqa[LAT-1][0];
  assign dp_unf  = dqa[LAT-1][1];

  task automatic set_op(input int i, input logic [23:0] a, input logic [23:0] b);
    req_op_a[i*24 +: 24] = a;
    req_op_b[i*24 +: 24] = b;
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = '0; req_lock = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = '0; req_lock = '0; req_op_a = '0; req_op_b = '0;
    #3 rst = 1'b0;
    @(negedge clk);
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset_issue_valid got %b want 0", issue_valid); end
    total++; if (issue_a !== 24'h0 || issue_b !== 24'h0) begin bad++; $display("FAIL reset_issue_ops got %h/%h want 0", issue_a, issue_b); end
    total++; if (res_valid !== 4'b0) begin bad++; $display("FAIL reset_res_valid got %b want 0000", res_valid); end
    total++; if (res_data !== 24'h0 || res_ovf !== 1'b0 || res_unf !== 1'b0) begin bad++; $display("FAIL reset_res got %h %b %b want 0", res_data, res_ovf, res_unf); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    set_op(0, 24'h3F0000, 24'h400000);
    req_valid = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got %b want 0001", req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy0 got %b want 0", busy); end
      end
      if (c == 1) begin
        total++; if (issue_valid !== 1'b1 || issue_a !== 24'h3F0000 || issue_b !== 24'h400000) begin bad++; $display("FAIL single_issue got %b %h %h want 1 3f0000 400000", issue_valid, issue_a, issue_b); end
      end
      if (c == 2) begin
        total++; if (issue_valid !== 1'b0 || issue_a !== 24'h3F0000) begin bad++; $display("FAIL single_issue_hold got %b %h want 0 3f0000", issue_valid, issue_a); end
      end
      if (c >= 1 && c <= 5) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy c%0d got %b want 1", c, busy); end
      end
      if (c == 5) begin
        total++; if (res_valid !== 4'b0001 || res_data !== 24'h400000 || res_ovf !== 1'b0 || res_unf !== 1'b0) begin bad++; $display("FAIL single_res got %b %h %b %b want 0001 400000 0 0", res_valid, res_data, res_ovf, res_unf); end
      end
      if (c == 6) begin
        total++; if (res_valid !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_after got %b busy %b want 0000 0", res_valid, busy); end
      end
      @(posedge clk); #1;
      req_valid = '0;
    end
  endtask

  task automatic test_fairness();
    int rem [N];
    logic [3:0] gr;
    logic [3:0] eg [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                           4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [23:0] bexp [8] = '{24'h410000, 24'h420000, 24'h430000, 24'h400000,
                              24'h410000, 24'h420000, 24'h430000, 24'h400000};
    do_reset();
    set_op(0, 24'h3F0000, 24'h400000);
    set_op(1, 24'h3F0000, 24'h410000);
    set_op(2, 24'h3F0000, 24'h420000);
    set_op(3, 24'h3F0000, 24'h430000);
    for (int i = 0; i < N; i++) rem[i] = 2;
    for (int c = 0; c < 15; c++) begin
      for (int i = 0; i < N; i++) req_valid[i] = (rem[i] > 0);
      @(negedge clk);
      gr = req_ready;
      total++; if (gr !== ((c < 8) ? eg[c] : 4'b0)) begin bad++; $display("FAIL fair_grant c%0d got %b want %b", c, gr, (c < 8) ? eg[c] : 4'b0); end
      if (c >= 1 && c <= 8) begin
        total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL fair_issue c%0d got %b want 1", c, issue_valid); end
      end
      if (c >= 5 && c < 13) begin
        total++; if (res_valid !== eg[c-5] || res_data !== bexp[c-5]) begin bad++; $display("FAIL fair_res c%0d got %b %h want %b %h", c, res_valid, res_data, eg[c-5], bexp[c-5]); end
      end else begin
        total++; if (res_valid !== 4'b0) begin bad++; $display("FAIL fair_nores c%0d got %b want 0000", c, res_valid); end
      end
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (gr[i]) rem[i]--;
    end
  endtask

  task automatic test_lock_limit();
    int rem [N];
    logic [3:0] gr;
    logic [3:0] e1 [12] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0100,
                            4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    do_reset();
    rem = '{1, 0, 10, 0};
    req_lock = 4'b0100;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) req_valid[i] = (rem[i] > 0);
      @(negedge clk);
      gr = req_ready;
      total++; if (gr !== e1[c]) begin bad++; $display("FAIL lock_limit c%0d got %b want %b", c, gr, e1[c]); end
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (gr[i]) rem[i]--;
    end
    do_reset();
    rem = '{0, 0, 10, 0};
    req_lock = 4'b0100;
    for (int c = 0; c < 11; c++) begin
      for (int i = 0; i < N; i++) req_valid[i] = (rem[i] > 0);
      @(negedge clk);
      gr = req_ready;
      total++; if (gr !== ((c < 10) ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL lock_solo c%0d got %b want %b", c, gr, (c < 10) ? 4'b0100 : 4'b0000); end
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (gr[i]) rem[i]--;
    end
    req_lock = '0;
  endtask

  task automatic test_flags();
    do_reset();
    set_op(1, 24'h3F0002, 24'h400000);
    set_op(3, 24'h3F0001, 24'h410000);
    req_valid = 4'b1010;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL flags_grant0 got %b want 0010", req_ready); end
      end
      if (c == 5) begin
        total++; if (res_valid !== 4'b0010 || res_data !== 24'h400000 || res_ovf !== 1'b0 || res_unf !== 1'b1) begin bad++; $display("FAIL flags_unf got %b %h %b %b want 0010 400000 0 1", res_valid, res_data, res_ovf, res_unf); end
      end
      if (c == 6) begin
        total++; if (res_valid !== 4'b1000 || res_data !== 24'h410000 || res_ovf !== 1'b1 || res_unf !== 1'b0) begin bad++; $display("FAIL flags_ovf got %b %h %b %b want 1000 410000 1 0", res_valid, res_data, res_ovf, res_unf); end
      end
      if (c == 7) begin
        total++; if (res_valid !== 4'b0 || res_data !== 24'h410000) begin bad++; $display("FAIL flags_hold got %b %h want 0000 410000", res_valid, res_data); end
      end
      @(posedge clk); #1;
      req_valid = (c == 0) ? 4'b1000 : 4'b0000;
    end
  endtask

  task automatic test_reset_midflight();
    logic [3:0] seq [3] = '{4'b1110, 4'b1100, 4'b1000};
    logic [3:0] eg  [3] = '{4'b0010, 4'b0100, 4'b1000};
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 24'h3F0000, 24'h400000);
    for (int c = 0; c < 3; c++) begin
      req_valid = seq[c];
      @(negedge clk);
      total++; if (req_ready !== eg[c]) begin bad++; $display("FAIL midrst_grant c%0d got %b want %b", c, req_ready, eg[c]); end
      @(posedge clk); #1;
    end
    req_valid = '0;
    rst = 1'b0;
    #1;
    total++; if (issue_valid !== 1'b0 || issue_a !== 24'h0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_clear got %b %h busy %b want 0 0 0", issue_valid, issue_a, busy); end
    total++; if (res_valid !== 4'b0 || res_data !== 24'h0) begin bad++; $display("FAIL midrst_res got %b %h want 0000 0", res_valid, res_data); end
    @(posedge clk); #1 rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++; if (res_valid !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_after c%0d got %b busy %b want 0000 0", c, res_valid, busy); end
    end
  endtask

  task automatic test_idle();
    do_reset();
    set_op(2, 24'h3F0000, 24'h420000);
    req_valid = 4'b0100;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      total++; if (req_ready !== ((c == 0) ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL idle_ready c%0d got %b", c, req_ready); end
      total++; if (issue_valid !== (c == 1)) begin bad++; $display("FAIL idle_issue c%0d got %b want %b", c, issue_valid, (c == 1)); end
      total++; if (res_valid !== ((c == 5) ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL idle_res c%0d got %b", c, res_valid); end
      total++; if (busy !== (c >= 1 && c <= 5)) begin bad++; $display("FAIL idle_busy c%0d got %b want %b", c, busy, (c >= 1 && c <= 5)); end
      @(posedge clk); #1;
      req_valid = '0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_lock_limit();
    test_flags();
    test_reset_midflight();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
